// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared bus widths, FSM state and owner encodings
package mem_port_arbiter_pkg;

    localparam int ADDR_BUS = 64;
    localparam int DATA_BUS = 64;
    localparam int INST_BUS = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int DATA_W = DATA_BUS,
    parameter int INST_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [INST_W-1:0] if_inst,
    output logic              if_busy,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] d_wmask,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [DATA_W-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    logic [1:0]        r_state;
    logic              r_own;
    logic              r_drop;
    logic              r_last_d;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_wmask;
    logic              r_if_done;
    logic              r_d_done;
    logic [INST_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_gnt;
    logic              w_gnt_d;
    logic              w_flush_if;
    logic              w_rsp;
    logic              w_ret_if;
    logic              w_ret_d;
    logic [INST_W-1:0] w_inst;

    // A requester whose done is pulsing this cycle is not eligible, so a
    // request still held during its own done cycle is never granted twice.
    assign if_busy    = if_req & ~r_if_done & ~if_flush;
    assign d_busy     = d_req & ~r_d_done;
    assign w_gnt      = (r_state == ST_IDLE) & (if_busy | d_busy);
    assign w_gnt_d    = d_busy & ~(if_busy & r_last_d);
    assign w_flush_if = if_flush & (r_own == OWN_IF) & (r_state != ST_IDLE);
    assign w_rsp      = (r_state == ST_WAIT) & mem_rsp_valid;
    assign w_ret_if   = w_rsp & (r_own == OWN_IF) & ~r_drop & ~if_flush;
    assign w_ret_d    = w_rsp & (r_own == OWN_D);
    assign w_inst     = r_addr[2] ? mem_rsp_rdata[2*INST_W-1:INST_W] : mem_rsp_rdata[INST_W-1:0];

    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;
    assign if_done       = r_if_done;
    assign if_inst       = r_if_inst;
    assign d_done        = r_d_done;
    assign d_rdata       = r_d_rdata;

    // Transaction FSM: grant and latch in IDLE, hold the request until accepted, await the response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_own    <= OWN_IF;
            r_drop   <= 1'b0;
            r_last_d <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
        end else begin
            if (w_gnt) begin
                r_state  <= ST_REQ;
                r_own    <= w_gnt_d ? OWN_D : OWN_IF;
                r_last_d <= w_gnt_d;
                r_we     <= w_gnt_d & d_we;
                r_addr   <= w_gnt_d ? d_addr : if_addr;
                r_wdata  <= w_gnt_d ? d_wdata : '0;
                r_wmask  <= w_gnt_d ? d_wmask : '0;
            end
            if ((r_state == ST_REQ) && mem_req_ready)
                r_state <= ST_WAIT;
            if (w_rsp)
                r_state <= ST_IDLE;
            r_drop <= w_rsp ? 1'b0 : (r_drop | w_flush_if);
        end
    end

    // Response register: one-cycle done pulses, data held between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_if_inst <= '0;
            r_d_rdata <= '0;
        end else begin
            r_if_done <= w_ret_if;
            r_d_done  <= w_ret_d;
            if (w_ret_if)
                r_if_inst <= w_inst;
            if (w_ret_d)
                r_d_rdata <= mem_rsp_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, d_wmask = '0;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;
    logic        if_done, if_busy, d_done, d_busy;
    logic [31:0] if_inst;
    logic [63:0] d_rdata;
    logic        mem_req_valid, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_req_wmask;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one outstanding transaction, accepted or not, dropped or not
    bit          m_act, m_acc, m_drop, m_d, m_last_d, m_we;
    logic [63:0] m_addr, m_wdata, m_wmask;
    bit          e_if_done, e_d_done;
    logic [31:0] e_if_inst;
    logic [63:0] e_d_rdata;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst), .if_busy(if_busy),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_done(d_done), .d_rdata(d_rdata), .d_busy(d_busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_acc = 0; m_drop = 0; m_d = 0; m_last_d = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0;
        e_if_done = 0; e_d_done = 0; e_if_inst = '0; e_d_rdata = '0;
    endtask

    task automatic compare();
        bit ev;
        ev = m_act && !m_acc;
        chk("mem_req_valid", mem_req_valid, ev);
        if (ev) begin
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_we", mem_req_we, m_we);
            chk("mem_req_wmask", mem_req_wmask, m_wmask);
            if (m_we) chk("mem_req_wdata", mem_req_wdata, m_wdata);
        end
        chk("if_done", if_done, e_if_done);
        chk("d_done", d_done, e_d_done);
        chk("if_inst", if_inst, e_if_inst);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("if_busy", if_busy, if_req && !e_if_done && !if_flush);
        chk("d_busy", d_busy, d_req && !e_d_done);
    endtask

    task automatic model_step();
        bit nif, nd, iok, dok;
        nif = 0; nd = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_act) begin
            iok = if_req && !if_flush && !e_if_done;
            dok = d_req && !e_d_done;
            if (iok || dok) begin
                m_d = dok && !(iok && m_last_d);
                m_last_d = m_d;
                m_act = 1; m_acc = 0; m_drop = 0;
                m_addr  = m_d ? d_addr : if_addr;
                m_we    = m_d && d_we;
                m_wdata = m_d ? d_wdata : 64'd0;
                m_wmask = m_d ? d_wmask : 64'd0;
            end
        end else begin
            if (!m_d && if_flush) m_drop = 1;
            if (!m_acc) begin
                if (mem_req_ready) m_acc = 1;
            end else if (mem_rsp_valid) begin
                m_act = 0;
                if (m_d) begin
                    nd = 1;
                    e_d_rdata = mem_rsp_rdata;
                end else if (!m_drop) begin
                    nif = 1;
                    e_if_inst = m_addr[2] ? mem_rsp_rdata[63:32] : mem_rsp_rdata[31:0];
                end
            end
        end
        e_if_done = nif;
        e_d_done = nd;
    endtask

    // Inputs are set at the negedge; outputs are checked 1 time unit later, then the model advances
    task automatic cycle();
        #1;
        compare();
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [63:0] rand_pc();
        return 64'h8000_0000 + 64'({$urandom_range(0, 1023), 2'b00});
    endfunction

    initial begin
        bit was_rst;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset mem_req_valid", mem_req_valid, 0);
        chk("reset mem_req_addr", mem_req_addr, 0);
        chk("reset mem_req_wmask", mem_req_wmask, 0);
        chk("reset if_done", if_done, 0);
        chk("reset d_done", d_done, 0);
        chk("reset if_inst", if_inst, 0);
        chk("reset d_rdata", d_rdata, 0);

        // Fetch only, best-case latency
        if_req = 1; if_addr = 64'h8000_0004; mem_req_ready = 1;
        cycle();
        chk("fetch valid", mem_req_valid, 1);
        chk("fetch addr", mem_req_addr, 64'h8000_0004);
        chk("fetch we", mem_req_we, 0);
        cycle();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h00100093_00000013;
        cycle();
        mem_rsp_valid = 0;
        chk("fetch done", if_done, 1);
        chk("fetch inst", if_inst, 32'h00100093);
        if_req = 0;
        cycle();
        chk("fetch done pulse", if_done, 0);

        // Flush during WAIT, then the redirected fetch returns its own data
        if_req = 1; if_addr = 64'h8000_0040;
        cycle();
        cycle();
        if_flush = 1; if_addr = 64'h8000_0100;
        cycle();
        if_flush = 0; mem_rsp_valid = 1; mem_rsp_rdata = 64'hDEADBEEF_CAFEF00D;
        cycle();
        mem_rsp_valid = 0;
        chk("flushed no done", if_done, 0);
        cycle();
        chk("redirect addr", mem_req_addr, 64'h8000_0100);
        cycle();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h11111111_22222222;
        cycle();
        mem_rsp_valid = 0;
        chk("redirect done", if_done, 1);
        chk("redirect inst", if_inst, 32'h22222222);
        if_req = 0;
        cycle();

        // Flush coincident with the response, then flush during a back-pressured REQ
        if_req = 1; if_addr = 64'h8000_0200;
        cycle();
        cycle();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h33333333_44444444; if_flush = 1; if_addr = 64'h8000_0300;
        cycle();
        mem_rsp_valid = 0; if_flush = 0;
        chk("coincident flush no done", if_done, 0);
        chk("coincident flush inst held", if_inst, 32'h22222222);
        mem_req_ready = 0;
        cycle();
        if_flush = 1; if_req = 0;
        cycle();
        if_flush = 0;
        chk("flushed REQ held", mem_req_valid, 1);
        chk("flushed REQ addr", mem_req_addr, 64'h8000_0300);
        mem_req_ready = 1;
        cycle();
        mem_rsp_valid = 1;
        cycle();
        mem_rsp_valid = 0;
        chk("flushed REQ no done", if_done, 0);

        // Reset while waiting for a response; a late response is ignored
        if_req = 1; if_addr = 64'h8000_0400;
        cycle();
        cycle();
        rst = 1; if_req = 0;
        cycle();
        rst = 0;
        chk("mid reset valid", mem_req_valid, 0);
        chk("mid reset addr", mem_req_addr, 0);
        chk("mid reset if_inst", if_inst, 0);
        chk("mid reset if_done", if_done, 0);
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h55555555_66666666;
        cycle();
        mem_rsp_valid = 0;
        chk("late rsp ignored", if_done, 0);
        chk("late rsp no req", mem_req_valid, 0);

        // Store alongside a fetch: D first with exact fields under 5 cycles of backpressure
        d_req = 1; d_we = 1; d_addr = 64'h8000_1000; d_wdata = 64'h11223344_55667788;
        d_wmask = 64'hFFFFFFFF_00000000; if_req = 1; if_addr = 64'h8000_0008; mem_req_ready = 0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            chk("bp valid", mem_req_valid, 1);
            chk("bp we", mem_req_we, 1);
            chk("bp addr", mem_req_addr, 64'h8000_1000);
            chk("bp wdata", mem_req_wdata, 64'h11223344_55667788);
            chk("bp wmask", mem_req_wmask, 64'hFFFFFFFF_00000000);
            chk("bp d_busy", d_busy, 1);
            cycle();
        end
        mem_req_ready = 1;
        cycle();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'hA5A5A5A5_5A5A5A5A;
        cycle();
        mem_rsp_valid = 0;
        chk("store done", d_done, 1);
        d_we = 0; d_addr = 64'h8000_2000;
        cycle();
        chk("store done pulse", d_done, 0);
        chk("IF after D addr", mem_req_addr, 64'h8000_0008);
        chk("IF after D we", mem_req_we, 0);
        cycle();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h77777777_88888888;
        cycle();
        mem_rsp_valid = 0;
        chk("IF after D done", if_done, 1);
        chk("IF after D inst", if_inst, 32'h88888888);
        if_req = 0;
        cycle();
        chk("load addr", mem_req_addr, 64'h8000_2000);
        cycle();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h0BADF00D_12345678;
        cycle();
        mem_rsp_valid = 0;
        chk("load done", d_done, 1);
        chk("load data", d_rdata, 64'h0BADF00D_12345678);
        d_req = 0;
        cycle();
        d_req = 1; d_addr = 64'h8000_3000; if_req = 1; if_addr = 64'h8000_0010;
        cycle();
        chk("fairness IF wins", mem_req_addr, 64'h8000_0010);

        // Randomized traffic; outstanding directed requests drain naturally
        was_rst = 0;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom % 200) == 0;
            if_flush = 0;
            if (!if_req || if_done) begin
                if_req = ($urandom % 3) != 0;
                if_addr = rand_pc();
            end else if ($urandom % 10 == 0) begin
                if_flush = 1;
                if_addr = rand_pc();
                if_req = $urandom % 2;
            end
            if (!d_req || d_done) begin
                d_req = $urandom % 2;
                d_we = $urandom % 2;
                d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
                d_wmask = {$urandom, $urandom};
            end
            mem_req_ready = ($urandom % 3) != 0;
            mem_rsp_valid = (m_act && m_acc && ($urandom % 2 == 1)) || (was_rst && ($urandom % 2 == 1));
            mem_rsp_rdata = {$urandom, $urandom};
            was_rst = rst;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the mem-stage load/store path.
- Sequences each transaction as: request handshake, then wait for the response, then return the data to the requester.
- Raises per-requester busy so the pipeline stall controller can freeze the IF and MEM stages.
- Sits between the if/mem stages and the external RAM/bus bridge.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data-port width; the write mask is also DATA_W bits (bit-granular mask)
- INST_W, 32, instruction width; fetch returns the addressed low/high word

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held until if_done or if_flush
- if_addr  in  ADDR_W  fetch PC, 4-byte aligned
- if_flush  in  1  jump redirect; cancels the outstanding fetch
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  INST_W  fetched instruction, bits selected by if_addr[2]
- if_busy  out  1  fetch requested and not yet done
- d_req  in  1  load/store request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W  store bit mask
- d_done  out  1  one-cycle pulse, load data valid / store complete
- d_rdata  out  DATA_W  load data
- d_busy  out  1  data requested and not yet done
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts the request
- mem_req_we  out  1  downstream write
- mem_req_addr  out  ADDR_W  downstream address
- mem_req_wdata  out  DATA_W  downstream write data
- mem_req_wmask  out  DATA_W  downstream write mask
- mem_rsp_valid  in  1  response valid; exactly one per accepted request, no earlier than the cycle after acceptance
- mem_rsp_rdata  in  DATA_W  response data

Behaviour:
- Reset values:
  - State IDLE; drop=0; last_d=0.
  - All outputs 0: if_done, d_done, if_inst, d_rdata, mem_req_*.
- States:
  - IDLE
  - REQ: mem_req_valid=1, fields from latched request registers.
  - WAIT: awaiting mem_rsp_valid.
  - A grant register (IF or D) records the owner.
- IDLE grant:
  - Only d_req set: grant D.
  - Only if_req set (and not if_flush): grant IF.
  - Both set: D, unless last_d=1, in which case IF. Prevents fetch starvation under back-to-back loads.
  - last_d is updated on every grant.
  - Grant latches addr/we/wdata/wmask; next state REQ.
  - A fetch grant always has we=0 and mask=0.
- REQ:
  - mem_req_valid stays 1 and fields stay stable until mem_req_ready; no withdrawal, even on flush.
  - On ready: go to WAIT.
- WAIT:
  - On mem_rsp_valid, go to IDLE.
  - Next cycle: the owner's done pulses with registered data (d_rdata = rdata; if_inst = rdata word selected by latched if_addr[2]), unless drop=1.
  - Data outputs hold their value between pulses.
- Latency: best case from request to done is 3 cycles: grant at edge 1, accept at edge 2 (ready already high), response the next cycle, done registered one cycle later. Back-to-back transactions have 1 idle cycle between them (IDLE re-arbitration).
- Flush:
  - if_flush with IF the owner in REQ or WAIT sets drop; that transaction completes downstream with no if_done.
  - if_flush in the same cycle as mem_rsp_valid also discards the response.
  - drop clears on return to IDLE.
  - if_flush in IDLE blocks an IF grant that cycle.
  - if_flush while D is the owner has no effect on D.
- Busy:
  - if_busy = if_req & ~if_done & ~if_flush.
  - d_busy = d_req & ~d_done.
  - Both are combinational so the stall controller can use them in the same cycle.
- Simultaneous events: a new request arriving during WAIT is not granted until IDLE.
- Mid-operation reset: returns to IDLE immediately and drops any outstanding response. The downstream bridge is reset by the same rst.

Decomposition:
- Shared defines file: ADDR_BUS/DATA_BUS/INST_BUS widths, state encodings, owner encoding (OWN_IF=0, OWN_D=1).
- No sub-module.
- Request latch, FSM and response register live in one module of roughly 200 lines.

Test Plan:
- Fetch only: if_addr=0x80000004, ready=1, rsp one cycle after accept with rdata=0x00100093_00000013 -> mem_req_addr=0x80000004, we=0; if_done pulses with if_inst=0x00100093, 3 cycles after request.
- Store then load, same cycle as a fetch: d_we=1, addr=0x80001000, wdata=0x1122334455667788, mask=0xFFFFFFFF00000000 plus if_req -> D granted first with exact fields, then IF; a second d_req after the first D is still served after IF (last_d fairness).
- Backpressure: mem_req_ready low 5 cycles -> mem_req_valid and all fields stable for 5 cycles; d_busy=1 throughout; one d_done only.
- Flush during WAIT: IF owner, if_flush pulsed before rsp -> no if_done; next fetch at 0x80000100 returns its own data, not the stale data.
- Flush coincident with mem_rsp_valid, and flush during REQ with ready low -> request held until accepted, response discarded, no if_done.
- Reset asserted in WAIT -> next cycle all outputs 0, state IDLE; a late mem_rsp_valid is ignored.
